// File: rtl/rename_rollback_ctrl_pkg.sv
// Shared types for the rename-stage rollback controller: physical tag layout,
// default ROB depth, rollback state encoding and the CDB ready-bypass helper.
package rename_rollback_ctrl_pkg;

    localparam int ROB_SZ_DEF = 32;
    localparam int PHYS_W     = 6;
    localparam int ARCH_W     = 5;

    typedef struct packed {
        logic [PHYS_W-1:0] phys_reg;
        logic              valid;
        logic              ready;
    } tag_t;

    typedef enum logic [1:0] {
        RB_IDLE = 2'd0,
        RB_WALK = 2'd1,
        RB_DONE = 2'd2
    } rb_state_t;

    // A T_old being restored picks up a completion broadcast in the same cycle,
    // since the ROB copy cannot have seen it yet.
    function automatic tag_t restore_tag(input tag_t told, input tag_t cdb, input logic cdb_en);
        tag_t t;
        t = told;
        if (cdb_en && (cdb.phys_reg == told.phys_reg)) begin
            t.ready = 1'b1;
        end else begin
            t.ready = told.ready;
        end
        return t;
    endfunction

endpackage

// File: rtl/rename_rollback_ctrl_chk.sv
// Protocol checker: a new rollback must not be requested while a walk is in flight.
module rename_rollback_ctrl_chk (
    input logic clock,
    input logic reset,
    input logic rollback_start,
    input logic walk_busy
);

    property p_no_start_while_busy;
        @(posedge clock) disable iff (!reset) !(rollback_start && walk_busy);
    endproperty

    a_no_start_while_busy: assert property (p_no_start_while_busy);

endmodule

// File: rtl/rollback_walker.sv
// Walk sequencer: holds the rollback state, the ROB pointer and the number of
// entries still to undo, and exposes WALK/DONE qualifiers to the top level.
module rollback_walker
    import rename_rollback_ctrl_pkg::*;
#(
    parameter int ROB_SZ = ROB_SZ_DEF,
    parameter int PTR_W  = $clog2(ROB_SZ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PTR_W-1:0] tail_idx,
    input  logic [PTR_W:0]   count,
    output logic             in_walk,
    output logic             in_done,
    output logic [PTR_W-1:0] ptr
);

    rb_state_t        state_r;
    rb_state_t        state_s;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_s;
    logic [PTR_W:0]   remaining_r;
    logic [PTR_W:0]   remaining_s;

    // State, pointer and remaining-count registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= RB_IDLE;
            ptr_r       <= '0;
            remaining_r <= '0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            remaining_r <= remaining_s;
        end
    end

    // Next-state logic; the pointer wraps naturally because ROB_SZ is a power of two.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        remaining_s = remaining_r;
        case (state_r)
            RB_IDLE: begin
                if (start) begin
                    ptr_s       = tail_idx;
                    remaining_s = count;
                    if (count != '0) begin
                        state_s = RB_WALK;
                    end else begin
                        state_s = RB_DONE;
                    end
                end else begin
                    state_s = RB_IDLE;
                end
            end
            RB_WALK: begin
                ptr_s       = ptr_r - PTR_W'(1);
                remaining_s = remaining_r - (PTR_W+1)'(1);
                if (remaining_r <= (PTR_W+1)'(1)) begin
                    state_s = RB_DONE;
                end else begin
                    state_s = RB_WALK;
                end
            end
            RB_DONE: begin
                state_s = RB_IDLE;
            end
            default: begin
                state_s     = RB_IDLE;
                ptr_s       = '0;
                remaining_s = '0;
            end
        endcase
    end

    assign in_walk = (state_r == RB_WALK);
    assign in_done = (state_r == RB_DONE);
    assign ptr     = ptr_r;

endmodule

// File: rtl/rename_rollback_ctrl.sv
// Map-table write-port owner in rename: forwards dispatch renames normally and,
// after a mispredict, walks the ROB youngest-first restoring T_old and freeing T_new.
module rename_rollback_ctrl
    import rename_rollback_ctrl_pkg::*;
#(
    parameter int ROB_SZ = ROB_SZ_DEF,
    parameter int PTR_W  = $clog2(ROB_SZ)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              disp_valid,
    input  logic [ARCH_W-1:0] disp_arch_idx,
    input  tag_t              disp_tag,
    output logic              disp_stall,
    input  logic              rollback_start,
    input  logic [PTR_W-1:0]  rollback_tail_idx,
    input  logic [PTR_W:0]    rollback_count,
    output logic [PTR_W-1:0]  rob_rd_idx,
    input  logic [ARCH_W-1:0] rob_rd_arch_idx,
    input  tag_t              rob_rd_told,
    input  tag_t              rob_rd_tnew,
    input  logic              rob_rd_has_dest,
    input  tag_t              cdb,
    input  logic              cdb_enable,
    output logic [ARCH_W-1:0] mt_write_idx,
    output tag_t              mt_write_tag,
    output logic              mt_write_en,
    output logic              fl_return_valid,
    output tag_t              fl_return_tag,
    output logic              walk_busy,
    output logic              walk_done
);

    logic             in_walk_s;
    logic             in_done_s;
    logic [PTR_W-1:0] ptr_s;

    rollback_walker #(
        .ROB_SZ (ROB_SZ),
        .PTR_W  (PTR_W)
    ) u_walker (
        .clock    (clock),
        .reset    (reset),
        .start    (rollback_start),
        .tail_idx (rollback_tail_idx),
        .count    (rollback_count),
        .in_walk  (in_walk_s),
        .in_done  (in_done_s),
        .ptr      (ptr_s)
    );

    rename_rollback_ctrl_chk u_chk (
        .clock          (clock),
        .reset          (reset),
        .rollback_start (rollback_start),
        .walk_busy      (walk_busy)
    );

    // Write-port mux and free-list return; everything is forced low while reset is held.
    always_comb begin
        disp_stall      = 1'b0;
        rob_rd_idx      = '0;
        mt_write_idx    = '0;
        mt_write_tag    = '0;
        mt_write_en     = 1'b0;
        fl_return_valid = 1'b0;
        fl_return_tag   = '0;
        walk_busy       = 1'b0;
        walk_done       = 1'b0;
        if (!reset) begin
            disp_stall = 1'b0;
        end else if (in_walk_s) begin
            disp_stall = 1'b1;
            walk_busy  = 1'b1;
            rob_rd_idx = ptr_s;
            if (rob_rd_has_dest) begin
                mt_write_en     = 1'b1;
                mt_write_idx    = rob_rd_arch_idx;
                mt_write_tag    = restore_tag(rob_rd_told, cdb, cdb_enable);
                fl_return_valid = 1'b1;
                fl_return_tag   = rob_rd_tnew;
            end else begin
                mt_write_en = 1'b0;
            end
        end else if (in_done_s) begin
            disp_stall = 1'b1;
            walk_busy  = 1'b1;
            walk_done  = 1'b1;
        end else begin
            // Idle: a dispatch alongside a rollback request is wrong-path and dropped.
            disp_stall = rollback_start;
            if (disp_valid && !rollback_start) begin
                mt_write_en  = 1'b1;
                mt_write_idx = disp_arch_idx;
                mt_write_tag = disp_tag;
            end else begin
                mt_write_en = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rename_rollback_ctrl.sv
// Bench for rename_rollback_ctrl: directed scenarios plus randomized traffic
// against a queue-based model of the walk order and map-table effects.
module tb_rename_rollback_ctrl;
    import rename_rollback_ctrl_pkg::*;

    localparam int ROB_SZ = 32;
    localparam int PTR_W  = 5;

    logic              clock;
    logic              reset;
    logic              disp_valid;
    logic [ARCH_W-1:0] disp_arch_idx;
    tag_t              disp_tag;
    logic              disp_stall;
    logic              rollback_start;
    logic [PTR_W-1:0]  rollback_tail_idx;
    logic [PTR_W:0]    rollback_count;
    logic [PTR_W-1:0]  rob_rd_idx;
    logic [ARCH_W-1:0] rob_rd_arch_idx;
    tag_t              rob_rd_told;
    tag_t              rob_rd_tnew;
    logic              rob_rd_has_dest;
    tag_t              cdb;
    logic              cdb_enable;
    logic [ARCH_W-1:0] mt_write_idx;
    tag_t              mt_write_tag;
    logic              mt_write_en;
    logic              fl_return_valid;
    tag_t              fl_return_tag;
    logic              walk_busy;
    logic              walk_done;

    // ROB contents as seen by the controller
    logic [ARCH_W-1:0] rob_arch [ROB_SZ];
    tag_t              rob_told [ROB_SZ];
    tag_t              rob_tnew [ROB_SZ];
    logic              rob_hd   [ROB_SZ];

    // Model state: remaining walk order and pending DONE cycle
    int   walk_q[$];
    bit   done_pend;
    tag_t tb_mt  [32];
    tag_t mdl_mt [32];

    int n_tests;
    int n_fail;

    rename_rollback_ctrl #(.ROB_SZ(ROB_SZ), .PTR_W(PTR_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .disp_valid        (disp_valid),
        .disp_arch_idx     (disp_arch_idx),
        .disp_tag          (disp_tag),
        .disp_stall        (disp_stall),
        .rollback_start    (rollback_start),
        .rollback_tail_idx (rollback_tail_idx),
        .rollback_count    (rollback_count),
        .rob_rd_idx        (rob_rd_idx),
        .rob_rd_arch_idx   (rob_rd_arch_idx),
        .rob_rd_told       (rob_rd_told),
        .rob_rd_tnew       (rob_rd_tnew),
        .rob_rd_has_dest   (rob_rd_has_dest),
        .cdb               (cdb),
        .cdb_enable        (cdb_enable),
        .mt_write_idx      (mt_write_idx),
        .mt_write_tag      (mt_write_tag),
        .mt_write_en       (mt_write_en),
        .fl_return_valid   (fl_return_valid),
        .fl_return_tag     (fl_return_tag),
        .walk_busy         (walk_busy),
        .walk_done         (walk_done)
    );

    assign rob_rd_arch_idx = rob_arch[rob_rd_idx];
    assign rob_rd_told     = rob_told[rob_rd_idx];
    assign rob_rd_tnew     = rob_tnew[rob_rd_idx];
    assign rob_rd_has_dest = rob_hd[rob_rd_idx];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    function automatic tag_t mk(input int p, input bit v, input bit r);
        tag_t t;
        t.phys_reg = PHYS_W'(p);
        t.valid    = v;
        t.ready    = r;
        return t;
    endfunction

    function automatic bit model_idle();
        return (walk_q.size() == 0) && !done_pend;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, ".stall"}, 32'(disp_stall), 32'd0);
        check({name, ".rdidx"}, 32'(rob_rd_idx), 32'd0);
        check({name, ".mten"},  32'(mt_write_en), 32'd0);
        check({name, ".mtidx"}, 32'(mt_write_idx), 32'd0);
        check({name, ".mttag"}, 32'(mt_write_tag), 32'd0);
        check({name, ".flv"},   32'(fl_return_valid), 32'd0);
        check({name, ".fltag"}, 32'(fl_return_tag), 32'd0);
        check({name, ".busy"},  32'(walk_busy), 32'd0);
        check({name, ".done"},  32'(walk_done), 32'd0);
    endtask

    // One clock of stimulus; checks outputs against the model, then advances it.
    task automatic step(input logic dv, input logic [4:0] da, input tag_t dt,
                        input logic rs, input logic [PTR_W-1:0] rt, input logic [PTR_W:0] rc,
                        input logic ce, input tag_t ct);
        logic             e_stall, e_busy, e_done, e_mten, e_flv;
        logic [PTR_W-1:0] e_idx;
        logic [4:0]       e_mtidx;
        tag_t             e_mttag, e_fltag;
        int               cur;
        @(negedge clock);
        disp_valid = dv; disp_arch_idx = da; disp_tag = dt;
        rollback_start = rs; rollback_tail_idx = rt; rollback_count = rc;
        cdb_enable = ce; cdb = ct;
        #1;
        e_stall = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_mten = 1'b0; e_flv = 1'b0;
        e_idx = '0; e_mtidx = '0; e_mttag = '0; e_fltag = '0;
        if (walk_q.size() > 0) begin
            cur = walk_q[0];
            e_stall = 1'b1; e_busy = 1'b1; e_idx = PTR_W'(cur);
            if (rob_hd[cur]) begin
                e_mten = 1'b1; e_mtidx = rob_arch[cur]; e_mttag = rob_told[cur];
                if (ce && ct.phys_reg == rob_told[cur].phys_reg) e_mttag.ready = 1'b1;
                e_flv = 1'b1; e_fltag = rob_tnew[cur];
            end
        end else if (done_pend) begin
            e_stall = 1'b1; e_busy = 1'b1; e_done = 1'b1;
        end else begin
            e_stall = rs;
            if (dv && !rs) begin
                e_mten = 1'b1; e_mtidx = da; e_mttag = dt;
            end
        end
        check("stall", 32'(disp_stall), 32'(e_stall));
        check("busy",  32'(walk_busy), 32'(e_busy));
        check("done",  32'(walk_done), 32'(e_done));
        check("mten",  32'(mt_write_en), 32'(e_mten));
        check("flv",   32'(fl_return_valid), 32'(e_flv));
        if (e_busy && !e_done) check("rdidx", 32'(rob_rd_idx), 32'(e_idx));
        if (e_mten) begin
            check("mtidx", 32'(mt_write_idx), 32'(e_mtidx));
            check("mttag", 32'(mt_write_tag), 32'(e_mttag));
        end
        if (e_flv) check("fltag", 32'(fl_return_tag), 32'(e_fltag));
        if (mt_write_en) tb_mt[mt_write_idx] = mt_write_tag;
        if (e_mten) mdl_mt[e_mtidx] = e_mttag;
        @(posedge clock);
        if (walk_q.size() > 0) begin
            void'(walk_q.pop_front());
            if (walk_q.size() == 0) done_pend = 1'b1;
        end else if (done_pend) begin
            done_pend = 1'b0;
        end else if (rs) begin
            for (int k = 0; k < int'(rc); k++) walk_q.push_back((int'(rt) - k + 2 * ROB_SZ) % ROB_SZ);
            if (rc == '0) done_pend = 1'b1;
        end
    endtask

    task automatic idle_cycle();
        step(1'b0, 5'd0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic start_walk(input logic [PTR_W-1:0] tail, input logic [PTR_W:0] cnt);
        step(1'b1, 5'd9, mk(50, 1'b1, 1'b0), 1'b1, tail, cnt, 1'b0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * ROB_SZ + 4 && !model_idle(); i++) idle_cycle();
    endtask

    task automatic randomize_rob();
        for (int i = 0; i < ROB_SZ; i++) begin
            rob_arch[i] = 5'($urandom);
            rob_told[i] = tag_t'(8'($urandom));
            rob_tnew[i] = tag_t'(8'($urandom));
            rob_hd[i]   = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        logic [PTR_W:0] rc;
        tag_t           ct;
        logic           ce;
        n_tests = 0; n_fail = 0; done_pend = 1'b0;
        for (int i = 0; i < 32; i++) begin tb_mt[i] = '0; mdl_mt[i] = '0; end
        randomize_rob();
        // Reset with live dispatch inputs: outputs must still be zero
        reset = 1'b0;
        disp_valid = 1'b1; disp_arch_idx = 5'd5; disp_tag = mk(40, 1'b1, 1'b0);
        rollback_start = 1'b0; rollback_tail_idx = '0; rollback_count = '0;
        cdb_enable = 1'b0; cdb = '0;
        #12;
        check_all_zero("rst");
        @(negedge clock);
        reset = 1'b1;

        // Normal dispatch
        step(1'b1, 5'd5, mk(40, 1'b1, 1'b0), 1'b0, '0, '0, 1'b0, '0);

        // Walk of 3 from tail 10 with a repeated arch register
        rob_arch[10] = 5'd3; rob_told[10] = mk(2, 1'b1, 1'b1); rob_tnew[10] = mk(33, 1'b1, 1'b0); rob_hd[10] = 1'b1;
        rob_hd[9] = 1'b0;
        rob_arch[8]  = 5'd3; rob_told[8]  = mk(3, 1'b1, 1'b1); rob_tnew[8]  = mk(34, 1'b1, 1'b0); rob_hd[8]  = 1'b1;
        start_walk(5'd10, 6'd3);
        drain();
        check("lastwins", 32'(tb_mt[3].phys_reg), 32'd3);

        // Wrap: tail 1, count 3 -> 1, 0, 31
        start_walk(5'd1, 6'd3);
        drain();

        // Same-cycle CDB bypass of the restored ready bit
        rob_arch[12] = 5'd7; rob_told[12] = mk(7, 1'b1, 1'b0); rob_tnew[12] = mk(45, 1'b1, 1'b0); rob_hd[12] = 1'b1;
        start_walk(5'd12, 6'd1);
        step(1'b0, 5'd0, '0, 1'b0, '0, '0, 1'b1, mk(7, 1'b1, 1'b1));
        check("cdbready", 32'(tb_mt[7].ready), 32'd1);
        drain();

        // Zero-length rollback, and full-ROB rollback
        start_walk(5'd4, 6'd0);
        drain();
        start_walk(5'd20, 6'd32);
        drain();

        // Reset in the middle of a walk
        start_walk(5'd6, 6'd5);
        idle_cycle();
        @(negedge clock);
        reset = 1'b0; disp_valid = 1'b1; disp_arch_idx = 5'd5; disp_tag = mk(40, 1'b1, 1'b0);
        #1;
        check_all_zero("midrst");
        @(negedge clock);
        reset = 1'b1;
        walk_q.delete(); done_pend = 1'b0;
        step(1'b1, 5'd5, mk(40, 1'b1, 1'b0), 1'b0, '0, '0, 1'b0, '0);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            ce = ($urandom_range(0, 2) == 0);
            ct = tag_t'(8'($urandom));
            if (walk_q.size() > 0 && $urandom_range(0, 1) == 1) ct = rob_told[walk_q[0]];
            if (model_idle() && $urandom_range(0, 7) == 0) begin
                randomize_rob();
                case ($urandom_range(0, 9))
                    0:       rc = 6'd0;
                    1:       rc = 6'd32;
                    default: rc = 6'($urandom_range(1, 12));
                endcase
                step($urandom_range(0, 1) == 1, 5'($urandom), tag_t'(8'($urandom)),
                     1'b1, 5'($urandom), rc, ce, ct);
            end else begin
                step($urandom_range(0, 1) == 1, 5'($urandom), tag_t'(8'($urandom)),
                     1'b0, 5'($urandom), 6'($urandom), ce, ct);
            end
        end
        drain();
        for (int i = 0; i < 32; i++) check($sformatf("mt%0d", i), 32'(tb_mt[i]), 32'(mdl_mt[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
